// File: rtl/assert_arbiter_if.sv
// Assertion-arbiter bus: source fire/mask vectors in, drainable ID log out.
//   expr_i    : per-source fire pulses (bit i = source i)
//   mask_i    : per-source mask, 1 = ignore new fires from that source
//   log_valid : log head valid
//   log_id    : source index at the log head
//   log_ready : consumer pops the head when log_valid & log_ready
// slave  = arbiter side, master = checker/host side.
interface assert_arbiter_if #(
  parameter int N_SRC = 8
);
  localparam int ID_W = $clog2(N_SRC);

  logic [N_SRC-1:0] expr_i;
  logic [N_SRC-1:0] mask_i;
  logic             log_valid;
  logic [ID_W-1:0]  log_id;
  logic             log_ready;

  modport slave (
    input  expr_i,
    input  mask_i,
    input  log_ready,
    output log_valid,
    output log_id
  );

  modport master (
    output expr_i,
    output mask_i,
    output log_ready,
    input  log_valid,
    input  log_id
  );
endinterface

// File: rtl/assert_arbiter.sv
// Central scheduler for assertion sources. Fire pulses from N_SRC checkers
// are latched into a pending vector, granted one per cycle in round-robin
// order and pushed as source IDs into a small log FIFO that the host drains.
// Granted failures are counted (saturating); reaching HALT_THRESH raises a
// sticky halt request and freezes capture.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   arm          : leave DISARMED and start capturing
//   clear        : flush everything back to DISARMED (rst has priority)
//   bus          : assert_arbiter_if.slave (expr_i, mask_i, log_*)
//   log_overflow : sticky, a grant was dropped because the log was full
//   fail_cnt     : granted failures since last clear, saturating
//   halt         : halt request, sticky until clear/rst
//   state        : 0 DISARMED, 1 ARMED, 2 TRIPPED, 3 HALTED
module assert_arbiter #(
  parameter int N_SRC       = 8,
  parameter int LOG_DEPTH   = 4,
  parameter int CNT_W       = 16,
  parameter int HALT_THRESH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               clear,
  assert_arbiter_if.slave    bus,
  output logic               log_overflow,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic               halt,
  output logic [1:0]         state
);

  localparam int ID_W  = $clog2(N_SRC);
  localparam int PTR_W = $clog2(LOG_DEPTH);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(HALT_THRESH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(LOG_DEPTH);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_TRIPPED  = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t            state_q, state_d;
  logic [N_SRC-1:0]  pend_q, pend_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              halt_q, halt_d;
  logic              ovf_q, ovf_d;

  logic [ID_W-1:0]   mem [LOG_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q, rd_nxt;
  logic [PTR_W:0]    count_q, count_d;
  logic              log_valid_q;
  logic [ID_W-1:0]   log_id_q, head_d;

  logic              active;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic [N_SRC-1:0]  grant_onehot;
  logic              pop, full, push, drop;

  assign active = (state_q == S_ARMED) || (state_q == S_TRIPPED);

  // Round-robin search: first pending bit at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!grant_vld && pend_q[ID_W'(idx)]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
    if (!active) grant_vld = 1'b0;
  end

  assign grant_onehot = grant_vld ? (N_SRC'(1) << grant_id) : '0;

  // A pop frees a slot in the same cycle, so a full log still accepts a push.
  assign pop  = log_valid_q & bus.log_ready;
  assign full = (count_q == FULL_CNT);
  assign push = grant_vld & (~full | pop);
  assign drop = grant_vld & full & ~pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Next head: the slot being written this cycle bypasses the memory.
  assign rd_nxt = rd_ptr_q + PTR_W'(pop);
  always_comb begin
    head_d = '0;
    if (count_d != '0) begin
      if (push && (rd_nxt == wr_ptr_q)) head_d = grant_id;
      else                              head_d = mem[rd_nxt];
    end
  end

  // Control FSM and capture/count next-state.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    halt_d   = halt_q;
    ovf_d    = ovf_q | drop;
    case (state_q)
      S_DISARMED: begin
        pend_d = '0;
        if (arm) state_d = S_ARMED;
      end
      S_ARMED, S_TRIPPED: begin
        // New sets are ORed in after the grant clear, so a re-fire survives.
        pend_d = (pend_q & ~grant_onehot) | (bus.expr_i & ~bus.mask_i);
        if (grant_vld) begin
          rr_ptr_d = (grant_id == ID_W'(N_SRC - 1)) ? '0 : grant_id + ID_W'(1);
          cnt_d    = sat_inc(cnt_q);
          if ((HALT_THRESH != 0) && (cnt_d == THRESH)) begin
            state_d = S_HALTED;
            halt_d  = 1'b1;
          end else begin
            state_d = S_TRIPPED;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q     <= S_DISARMED;
      pend_q      <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      halt_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      log_valid_q <= 1'b0;
      log_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      halt_q      <= halt_d;
      ovf_q       <= ovf_d;
      rd_ptr_q    <= rd_nxt;
      wr_ptr_q    <= wr_ptr_q + PTR_W'(push);
      count_q     <= count_d;
      log_valid_q <= (count_d != '0);
      log_id_q    <= head_d;
    end
  end

  // Log storage carries no reset; pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= grant_id;
  end

  assign bus.log_valid = log_valid_q;
  assign bus.log_id    = log_id_q;
  assign log_overflow  = ovf_q;
  assign fail_cnt      = cnt_q;
  assign halt          = halt_q;
  assign state         = state_q;

endmodule

// File: tb/tb_assert_arbiter.sv
module tb_assert_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // dut0: HALT_THRESH=0, dut1: HALT_THRESH=1, dut5: HALT_THRESH=5
  assert_arbiter_if #(.N_SRC(8)) if0 ();
  assert_arbiter_if #(.N_SRC(8)) if1 ();
  assert_arbiter_if #(.N_SRC(8)) if5 ();

  logic arm0 = 0, clear0 = 0, ovf0, halt0;
  logic arm1 = 0, clear1 = 0, ovf1, halt1;
  logic arm5 = 0, clear5 = 0, ovf5, halt5;
  logic [15:0] cnt0, cnt1, cnt5;
  logic [1:0]  st0, st1, st5;

  assert_arbiter #(.N_SRC(8), .LOG_DEPTH(4), .CNT_W(16), .HALT_THRESH(0)) dut0 (
    .clk(clk), .rst(rst), .arm(arm0), .clear(clear0), .bus(if0.slave),
    .log_overflow(ovf0), .fail_cnt(cnt0), .halt(halt0), .state(st0));
  assert_arbiter #(.N_SRC(8), .LOG_DEPTH(4), .CNT_W(16), .HALT_THRESH(1)) dut1 (
    .clk(clk), .rst(rst), .arm(arm1), .clear(clear1), .bus(if1.slave),
    .log_overflow(ovf1), .fail_cnt(cnt1), .halt(halt1), .state(st1));
  assert_arbiter #(.N_SRC(8), .LOG_DEPTH(4), .CNT_W(16), .HALT_THRESH(5)) dut5 (
    .clk(clk), .rst(rst), .arm(arm5), .clear(clear5), .bus(if5.slave),
    .log_overflow(ovf5), .fail_cnt(cnt5), .halt(halt5), .state(st5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (st1 !== 2'd0)       begin n_fail++; $display("FAIL rst_state got %0d exp 0", st1); end
    n_checks++; if (if1.log_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b exp 0", if1.log_valid); end
    n_checks++; if (if1.log_id !== 3'd0) begin n_fail++; $display("FAIL rst_id got %0d exp 0", if1.log_id); end
    n_checks++; if (ovf1 !== 1'b0)      begin n_fail++; $display("FAIL rst_ovf got %0b exp 0", ovf1); end
    n_checks++; if (cnt1 !== 16'd0)     begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", cnt1); end
    n_checks++; if (halt1 !== 1'b0)     begin n_fail++; $display("FAIL rst_halt got %0b exp 0", halt1); end
    // Disarmed: fires are ignored
    if0.expr_i = 8'hFF; tick(); tick(); tick(); if0.expr_i = 8'h00;
    n_checks++; if (if0.log_valid !== 1'b0) begin n_fail++; $display("FAIL disarm_valid got %0b exp 0", if0.log_valid); end
    n_checks++; if (cnt0 !== 16'd0)     begin n_fail++; $display("FAIL disarm_cnt got %0d exp 0", cnt0); end
  endtask

  task automatic test_single_halt();
    do_reset();
    arm1 = 1'b1; tick(); arm1 = 1'b0;
    n_checks++; if (st1 !== 2'd1) begin n_fail++; $display("FAIL t1_armed got %0d exp 1", st1); end
    if1.expr_i = 8'h04; tick(); if1.expr_i = 8'h00;
    n_checks++; if (if1.log_valid !== 1'b0) begin n_fail++; $display("FAIL t1_latency got %0b exp 0", if1.log_valid); end
    tick();
    n_checks++; if (if1.log_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid got %0b exp 1", if1.log_valid); end
    n_checks++; if (if1.log_id !== 3'd2) begin n_fail++; $display("FAIL t1_id got %0d exp 2", if1.log_id); end
    n_checks++; if (cnt1 !== 16'd1) begin n_fail++; $display("FAIL t1_cnt got %0d exp 1", cnt1); end
    n_checks++; if (st1 !== 2'd3) begin n_fail++; $display("FAIL t1_state got %0d exp 3", st1); end
    n_checks++; if (halt1 !== 1'b1) begin n_fail++; $display("FAIL t1_halt got %0b exp 1", halt1); end
    if1.expr_i = 8'hFF; tick(); tick(); if1.expr_i = 8'h00; tick();
    n_checks++; if (cnt1 !== 16'd1) begin n_fail++; $display("FAIL t1_frozen_cnt got %0d exp 1", cnt1); end
    n_checks++; if (if1.log_id !== 3'd2) begin n_fail++; $display("FAIL t1_held_id got %0d exp 2", if1.log_id); end
    if1.log_ready = 1'b1; tick(); if1.log_ready = 1'b0;
    n_checks++; if (if1.log_valid !== 1'b0) begin n_fail++; $display("FAIL t1_drain got %0b exp 0", if1.log_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    arm0 = 1'b1; tick(); arm0 = 1'b0;
    if0.log_ready = 1'b1;
    if0.expr_i = 8'hFF; tick(); if0.expr_i = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++; if (if0.log_valid !== 1'b1 || if0.log_id !== 3'(k))
        begin n_fail++; $display("FAIL t2_seq%0d got v=%0b id=%0d exp v=1 id=%0d", k, if0.log_valid, if0.log_id, k); end
    end
    n_checks++; if (cnt0 !== 16'd8) begin n_fail++; $display("FAIL t2_cnt got %0d exp 8", cnt0); end
    n_checks++; if (st0 !== 2'd2) begin n_fail++; $display("FAIL t2_state got %0d exp 2", st0); end
    n_checks++; if (halt0 !== 1'b0) begin n_fail++; $display("FAIL t2_halt got %0b exp 0", halt0); end
    tick();
    n_checks++; if (if0.log_valid !== 1'b0) begin n_fail++; $display("FAIL t2_empty got %0b exp 0", if0.log_valid); end
    if0.expr_i = 8'h81; tick(); if0.expr_i = 8'h00;
    tick();
    n_checks++; if (if0.log_id !== 3'd0) begin n_fail++; $display("FAIL t2_wrap0 got %0d exp 0", if0.log_id); end
    tick();
    n_checks++; if (if0.log_id !== 3'd7) begin n_fail++; $display("FAIL t2_wrap7 got %0d exp 7", if0.log_id); end
    n_checks++; if (cnt0 !== 16'd10) begin n_fail++; $display("FAIL t2_cnt10 got %0d exp 10", cnt0); end
    if0.log_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    arm0 = 1'b1; tick(); arm0 = 1'b0;
    if0.log_ready = 1'b0;
    if0.expr_i = 8'h3F; tick(); if0.expr_i = 8'h00;
    tick();
    n_checks++; if (if0.log_id !== 3'd0) begin n_fail++; $display("FAIL t3_first got %0d exp 0", if0.log_id); end
    for (int k = 0; k < 6; k++) tick();
    n_checks++; if (cnt0 !== 16'd6) begin n_fail++; $display("FAIL t3_cnt got %0d exp 6", cnt0); end
    n_checks++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL t3_ovf got %0b exp 1", ovf0); end
    n_checks++; if (if0.log_valid !== 1'b1 || if0.log_id !== 3'd0)
      begin n_fail++; $display("FAIL t3_stall got v=%0b id=%0d exp v=1 id=0", if0.log_valid, if0.log_id); end
    if0.log_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      n_checks++; if (if0.log_valid !== 1'b1 || if0.log_id !== 3'(k))
        begin n_fail++; $display("FAIL t3_pop%0d got v=%0b id=%0d exp v=1 id=%0d", k, if0.log_valid, if0.log_id, k); end
    end
    tick();
    n_checks++; if (if0.log_valid !== 1'b0) begin n_fail++; $display("FAIL t3_empty got %0b exp 0", if0.log_valid); end
    if0.log_ready = 1'b0;
  endtask

  task automatic test_mask();
    do_reset();
    arm0 = 1'b1; tick(); arm0 = 1'b0;
    if0.mask_i = 8'h01; if0.expr_i = 8'h01;
    tick(); tick(); tick();
    n_checks++; if (if0.log_valid !== 1'b0) begin n_fail++; $display("FAIL t4_valid got %0b exp 0", if0.log_valid); end
    n_checks++; if (cnt0 !== 16'd0) begin n_fail++; $display("FAIL t4_cnt got %0d exp 0", cnt0); end
    n_checks++; if (st0 !== 2'd1) begin n_fail++; $display("FAIL t4_state got %0d exp 1", st0); end
    if0.mask_i = 8'h00; tick();
    if0.mask_i = 8'h01; tick();
    n_checks++; if (if0.log_valid !== 1'b1 || if0.log_id !== 3'd0)
      begin n_fail++; $display("FAIL t4_pend_grant got v=%0b id=%0d exp v=1 id=0", if0.log_valid, if0.log_id); end
    n_checks++; if (cnt0 !== 16'd1) begin n_fail++; $display("FAIL t4_cnt1 got %0d exp 1", cnt0); end
    tick(); tick();
    n_checks++; if (cnt0 !== 16'd1) begin n_fail++; $display("FAIL t4_no_reset got %0d exp 1", cnt0); end
    if0.mask_i = 8'h00; if0.expr_i = 8'h00;
  endtask

  task automatic test_clear();
    do_reset();
    arm0 = 1'b1; tick(); arm0 = 1'b0;
    if0.log_ready = 1'b0;
    if0.expr_i = 8'hFF; tick(); if0.expr_i = 8'h00;
    for (int k = 0; k < 9; k++) tick();
    n_checks++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL t5_pre_ovf got %0b exp 1", ovf0); end
    if0.log_ready = 1'b1; tick();
    clear0 = 1'b1; arm0 = 1'b1; tick(); clear0 = 1'b0; arm0 = 1'b0;
    n_checks++; if (st0 !== 2'd0) begin n_fail++; $display("FAIL t5_state got %0d exp 0", st0); end
    n_checks++; if (if0.log_valid !== 1'b0 || if0.log_id !== 3'd0)
      begin n_fail++; $display("FAIL t5_log got v=%0b id=%0d exp v=0 id=0", if0.log_valid, if0.log_id); end
    n_checks++; if (cnt0 !== 16'd0) begin n_fail++; $display("FAIL t5_cnt got %0d exp 0", cnt0); end
    n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL t5_ovf got %0b exp 0", ovf0); end
    n_checks++; if (halt0 !== 1'b0) begin n_fail++; $display("FAIL t5_halt got %0b exp 0", halt0); end
    arm0 = 1'b1; tick(); arm0 = 1'b0;
    n_checks++; if (st0 !== 2'd1) begin n_fail++; $display("FAIL t5_rearm got %0d exp 1", st0); end
    if0.log_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    arm5 = 1'b1; tick(); arm5 = 1'b0;
    if5.log_ready = 1'b0;
    if5.expr_i = 8'h08;
    tick();
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if (cnt5 !== 16'd4) begin n_fail++; $display("FAIL t6_cnt4 got %0d exp 4", cnt5); end
    n_checks++; if (st5 !== 2'd2 || halt5 !== 1'b0)
      begin n_fail++; $display("FAIL t6_pre got st=%0d halt=%0b exp st=2 halt=0", st5, halt5); end
    n_checks++; if (if5.log_valid !== 1'b1 || if5.log_id !== 3'd3)
      begin n_fail++; $display("FAIL t6_head got v=%0b id=%0d exp v=1 id=3", if5.log_valid, if5.log_id); end
    // Full log: pop and push in the same cycle must not overflow.
    if5.log_ready = 1'b1;
    tick();
    n_checks++; if (cnt5 !== 16'd5) begin n_fail++; $display("FAIL t6_cnt5 got %0d exp 5", cnt5); end
    n_checks++; if (st5 !== 2'd3 || halt5 !== 1'b1)
      begin n_fail++; $display("FAIL t6_halt got st=%0d halt=%0b exp st=3 halt=1", st5, halt5); end
    n_checks++; if (ovf5 !== 1'b0) begin n_fail++; $display("FAIL t6_ovf got %0b exp 0", ovf5); end
    tick();
    n_checks++; if (cnt5 !== 16'd5) begin n_fail++; $display("FAIL t6_frozen got %0d exp 5", cnt5); end
    tick(); tick();
    n_checks++; if (if5.log_valid !== 1'b1 || if5.log_id !== 3'd3)
      begin n_fail++; $display("FAIL t6_last got v=%0b id=%0d exp v=1 id=3", if5.log_valid, if5.log_id); end
    tick();
    n_checks++; if (if5.log_valid !== 1'b0) begin n_fail++; $display("FAIL t6_empty got %0b exp 0", if5.log_valid); end
    if5.expr_i = 8'h00; if5.log_ready = 1'b0;
  endtask

  initial begin
    if0.expr_i = '0; if0.mask_i = '0; if0.log_ready = 1'b0;
    if1.expr_i = '0; if1.mask_i = '0; if1.log_ready = 1'b0;
    if5.expr_i = '0; if5.mask_i = '0; if5.log_ready = 1'b0;
    #2;
    test_reset();
    test_single_halt();
    test_round_robin();
    test_overflow();
    test_mask();
    test_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/assert_arbiter.md
Name: assert_arbiter

Overview:
- Central scheduler for assertion sources in the linked-list design.
- Collects fire pulses from N_SRC checker instances and serialises them, one per cycle, into a drainable ID log using round-robin arbitration.
- Counts failures and raises a single halt request once a threshold is reached.
- Sits between the per-block assertion checkers and the testbench/debug host, which drains the log and acts on halt.

Parameters:
N_SRC, 8, number of assertion sources (>=2)
LOG_DEPTH, 4, entries in ID log FIFO (power of 2, >=2)
CNT_W, 16, width of failure counter
HALT_THRESH, 1, failure count that triggers halt; 0 = never halt

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
arm  in  1  start capturing (DISARMED only)
clear  in  1  return to DISARMED, flush all state
expr_i  in  N_SRC  per-source fire, bit i = source i asserted this cycle
mask_i  in  N_SRC  per-source mask, 1 = ignore source
log_valid  out  1  log head valid
log_id  out  $clog2(N_SRC)  source index at log head
log_ready  in  1  consumer pops head when log_valid & log_ready
log_overflow  out  1  sticky: a grant was dropped because the log was full
fail_cnt  out  CNT_W  granted failures since last clear, saturating
halt  out  1  halt request, sticky until clear/rst
state  out  2  0 DISARMED, 1 ARMED, 2 TRIPPED, 3 HALTED

Behaviour:
- Reset (rst=1 at edge): state=DISARMED; pend_q=0; rr_ptr=0; FIFO empty. All outputs 0: log_valid, log_id, log_overflow, fail_cnt, halt.
- clear=1 at edge: same effect as rst, except that rst always takes priority. clear beats arm in the same cycle.
- DISARMED:
  - expr_i ignored; pend_q holds 0.
  - arm=1 -> ARMED at next edge.
  - arm in any other state is ignored.
- Capture (ARMED, TRIPPED): pend_q <= (pend_q & ~grant_onehot) | (expr_i & ~mask_i).
  - A set and a grant of the same bit in one cycle: the set wins, so the new event stays pending.
  - Masking only gates new sets; already pending bits are still granted.
- Arbitration (ARMED, TRIPPED), per cycle:
  - If pend_q != 0: grant the lowest-indexed set bit at or above rr_ptr, wrapping past N_SRC-1 to 0.
  - On a grant: rr_ptr <= granted index + 1 (mod N_SRC); fail_cnt += 1, saturating at all-ones.
  - Grant ID is pushed to the FIFO if not full. If full, it is dropped and log_overflow <= 1; fail_cnt still increments.
  - A push on a full FIFO in the same cycle as a pop succeeds; no overflow is flagged.
- Latency: expr_i high before edge t sets pend_q at t. The grant occurs in the following cycle, so log_valid is high after edge t+1 (2 cycles, empty FIFO, no contention).
- State transitions:
  - ARMED -> TRIPPED on the first grant.
  - TRIPPED -> HALTED at the edge where the post-increment fail_cnt == HALT_THRESH (HALT_THRESH != 0); halt <= 1 at that same edge.
  - With HALT_THRESH=1: ARMED -> HALTED directly on the first grant.
  - HALTED exits only via clear/rst.
- HALTED:
  - No captures or grants; pend_q and fail_cnt frozen.
  - Log draining continues normally.
- FIFO interface:
  - log_id and log_valid are registered outputs.
  - log_id is stable while log_valid & ~log_ready.
  - log_id = 0 when empty.
  - Pops are allowed in every state.

Test Plan:
1. rst, arm, pulse expr_i=8'h04 one cycle (mask=0) -> log_valid 2 cycles later, log_id=2, fail_cnt=1; HALT_THRESH=1 gives state=3, halt=1. Further expr ignored; log drains.
2. HALT_THRESH=0, expr_i=8'hFF one cycle, log_ready=1 -> IDs 0..7 in order, one per cycle, fail_cnt=8, state=2, halt=0. Then expr_i=8'h81 with rr_ptr=0 -> IDs 0, 7.
3. HALT_THRESH=0, log_ready=0, fire 6 distinct sources -> 4 IDs logged, log_overflow=1, fail_cnt=6. Raise log_ready -> 4 pops, first ID stable while stalled.
4. mask_i=8'h01, expr_i=8'h01 held -> no log entries, fail_cnt=0, state=1. Same cycle source 0 fires while pending unmasked -> the pending bit is still granted.
5. Mid-drain: assert clear together with arm -> next cycle state=0, log_valid=0, fail_cnt=0, overflow=0, halt=0; arm -> state=1.
6. Hold expr_i bit 3 continuously, HALT_THRESH=5 -> ID 3 granted every cycle. halt=1 at the edge where fail_cnt reaches 5; exactly 4 log entries plus the last push subject to FIFO space.
